// File: rtl/alu_logic_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_logic_pipe_if
// Handshake and data bundle between operand fetch, the pipelined logic unit
// and the ALU result mux.
//
//   Producer side : in_valid, LogicSelect, LHSIn, RHSIn -> ; <- in_ready
//   Consumer side : <- out_valid, RHSOut, ZeroOut, SignOut ; out_ready ->
//
// Modports:
//   master - the environment: it drives the operands and out_ready.
//   slave  - the logic unit: it drives in_ready and the result signals.
//
// Build option ALU_LOGIC_PARITY_EN adds ParityOut to the bundle.
// -----------------------------------------------------------------------------
interface alu_logic_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       LogicSelect;
  logic [WIDTH-1:0] LHSIn;
  logic [WIDTH-1:0] RHSIn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] RHSOut;
  logic             ZeroOut;
  logic             SignOut;
`ifdef ALU_LOGIC_PARITY_EN
  logic             ParityOut;
`endif

  modport master (
    output in_valid, LogicSelect, LHSIn, RHSIn, out_ready,
    input  in_ready, out_valid, RHSOut, ZeroOut, SignOut
`ifdef ALU_LOGIC_PARITY_EN
    , input ParityOut
`endif
  );

  modport slave (
    input  in_valid, LogicSelect, LHSIn, RHSIn, out_ready,
    output in_ready, out_valid, RHSOut, ZeroOut, SignOut
`ifdef ALU_LOGIC_PARITY_EN
    , output ParityOut
`endif
  );
endinterface

// File: rtl/alu_logic_pipe.sv
// -----------------------------------------------------------------------------
// alu_logic_pipe
// Two-stage pipelined logic unit. Any of the 16 two-input boolean functions is
// selected by a 4-bit truth-table code: result bit i is
// LogicSelect[{LHS[i], RHS[i]}]. Stage 1 captures the operands, stage 2 holds
// the result and its zero/sign flags. Both stages use valid/ready handshakes,
// so the unit can stall indefinitely without losing or duplicating results.
//
// Parameters:
//   WIDTH              operand/result width (>= 2)
//   FLAG_ZERO_ALL_ONES 1: ZeroOut also flags an all-ones result
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous drop of every in-flight operation
//   bus    alu_logic_pipe_if.slave (operands in, result and flags out)
//
// Build option ALU_LOGIC_PARITY_EN adds ParityOut, the XOR-reduce of the
// registered result.
// -----------------------------------------------------------------------------
module alu_logic_pipe #(
  parameter int WIDTH              = 8,
  parameter int FLAG_ZERO_ALL_ONES = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  alu_logic_pipe_if.slave bus
);

  // Stage 1: captured operands and function code
  logic             s1_valid;
  logic [3:0]       s1_sel;
  logic [WIDTH-1:0] s1_lhs;
  logic [WIDTH-1:0] s1_rhs;

  // Stage 2: registered result and flags
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             sign_q;

  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             in_ready;
  logic             accept;
  logic             s2_load;

  // Stage 1 frees up when it is empty, or when its content can move into
  // stage 2 this cycle (stage 2 empty or being drained).
  assign in_ready = !s1_valid || !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid_q || bus.out_ready);

  // Each operand bit pair indexes the truth table directly.
  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = s1_sel[{s1_lhs[i], s1_rhs[i]}];
    end
  end

  assign result_zero = (result == '0) ||
                       ((FLAG_ZERO_ALL_ONES != 0) && (&result));

  // Stage 1 register. flush wins over a simultaneous accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every register samples
      // pre-edge values regardless of block ordering.
      s1_valid <= 1'b0;
      // NOTE: datapath registers are cleared too, so the outputs start from a
      // known zero value rather than X.
      s1_sel   <= '0;
      s1_lhs   <= '0;
      s1_rhs   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sel   <= bus.LogicSelect;
      s1_lhs   <= bus.LHSIn;
      s1_rhs   <= bus.RHSIn;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register. Loading while the old result is consumed keeps
  // out_valid high across the edge; with no load, a consumed result empties
  // the stage. Data and flags only change on a load, so they are stable
  // while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= 1'b1;
      res_q       <= result;
      zero_q      <= result_zero;
      sign_q      <= result[WIDTH-1];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef ALU_LOGIC_PARITY_EN
  logic parity_q;

  // Parity tracks the stage-2 load and is cleared together with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (flush) begin
      parity_q <= 1'b0;
    end else if (s2_load) begin
      parity_q <= ^result;
    end
  end

  assign bus.ParityOut = parity_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.RHSOut    = res_q;
  assign bus.ZeroOut   = zero_q;
  assign bus.SignOut   = sign_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_logic_pipe
// Self-checking bench for alu_logic_pipe: a table of single operations with
// hand-derived results, hand-written sequences for back-to-back issue, stall,
// flush and asynchronous reset, a 16-bit instance with FLAG_ZERO_ALL_ONES=1,
// and a randomized run checked against a minterm-based reference model with a
// scoreboard queue. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_logic_pipe;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic flush  = 1'b0;
  logic wflush = 1'b0;

  always #5 clk = ~clk;

  alu_logic_pipe_if #(.WIDTH(8))  b();
  alu_logic_pipe_if #(.WIDTH(16)) wb();

  alu_logic_pipe #(.WIDTH(8), .FLAG_ZERO_ALL_ONES(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b.slave)
  );

  alu_logic_pipe #(.WIDTH(16), .FLAG_ZERO_ALL_ONES(1)) u_wide (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (wflush),
    .bus   (wb.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic [7:0] res;
    logic       z;
    logic       s;
    logic       p;
    string      name;
  } vec_t;

  vec_t vecs[16];

  // AND, OR, XOR, NOT LHS of 0xCA/0x5C
  logic [3:0] bsel[4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};
  logic [7:0] bexp[4] = '{8'h48, 8'hDE, 8'h96, 8'h35};
  logic       bsgn[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: OR of the selected minterms.
  function automatic logic [7:0] ref_fn(input logic [3:0] sel,
                                        input logic [7:0] l,
                                        input logic [7:0] r);
    logic [7:0] y;
    y = '0;
    if (sel[3]) y = y | (l & r);
    if (sel[2]) y = y | (l & ~r);
    if (sel[1]) y = y | (~l & r);
    if (sel[0]) y = y | (~l & ~r);
    return y;
  endfunction

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: accept, check latency 2 and the result.
  task automatic run_single(input logic [3:0] sel, input logic [7:0] l,
                            input logic [7:0] r, input logic [7:0] res,
                            input logic z, input logic s, input logic p,
                            input string nm);
    b.in_valid    = 1'b1;
    b.LogicSelect = sel;
    b.LHSIn       = l;
    b.RHSIn       = r;
    b.out_ready   = 1'b1;
    @(negedge clk);
    check({nm, " in_ready"}, b.in_ready, 1);
    to_drive();
    b.in_valid = 1'b0;
    @(negedge clk);
    check({nm, " valid_cycle1"}, b.out_valid, 0);
    to_drive();
    @(negedge clk);
    check({nm, " valid_cycle2"}, b.out_valid, 1);
    check({nm, " result"}, b.RHSOut, res);
    check({nm, " zero"}, b.ZeroOut, z);
    check({nm, " sign"}, b.SignOut, s);
`ifdef ALU_LOGIC_PARITY_EN
    check({nm, " parity"}, b.ParityOut, p);
`endif
    to_drive();
  endtask

  task automatic run_wide(input logic [3:0] sel, input logic [15:0] l,
                          input logic [15:0] r, input logic [15:0] res,
                          input logic z, input logic s, input logic p,
                          input string nm);
    wb.in_valid    = 1'b1;
    wb.LogicSelect = sel;
    wb.LHSIn       = l;
    wb.RHSIn       = r;
    wb.out_ready   = 1'b1;
    to_drive();
    wb.in_valid = 1'b0;
    @(negedge clk);
    check({nm, " valid_cycle1"}, wb.out_valid, 0);
    to_drive();
    @(negedge clk);
    check({nm, " valid_cycle2"}, wb.out_valid, 1);
    check({nm, " result"}, wb.RHSOut, res);
    check({nm, " zero"}, wb.ZeroOut, z);
    check({nm, " sign"}, wb.SignOut, s);
`ifdef ALU_LOGIC_PARITY_EN
    check({nm, " parity"}, wb.ParityOut, p);
`endif
    to_drive();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         idx;
    logic [7:0] held;
    bit         have_held;
    bit         seen;
    bit         pv, pr, pf;
    logic [7:0] pres;
    logic [7:0] e;
    logic [7:0] q[$];

    vecs[0]  = '{4'b1000, 8'hCA, 8'h5C, 8'h48, 1'b0, 1'b0, 1'b0, "and"};
    vecs[1]  = '{4'b1110, 8'hCA, 8'h5C, 8'hDE, 1'b0, 1'b1, 1'b0, "or"};
    vecs[2]  = '{4'b0110, 8'hCA, 8'h5C, 8'h96, 1'b0, 1'b1, 1'b0, "xor"};
    vecs[3]  = '{4'b1001, 8'hCA, 8'h5C, 8'h69, 1'b0, 1'b0, 1'b0, "xnor"};
    vecs[4]  = '{4'b0111, 8'hCA, 8'h5C, 8'hB7, 1'b0, 1'b1, 1'b0, "nand"};
    vecs[5]  = '{4'b0001, 8'hCA, 8'h5C, 8'h21, 1'b0, 1'b0, 1'b0, "nor"};
    vecs[6]  = '{4'b1100, 8'hCA, 8'h5C, 8'hCA, 1'b0, 1'b1, 1'b0, "pass_lhs"};
    vecs[7]  = '{4'b1010, 8'hCA, 8'h5C, 8'h5C, 1'b0, 1'b0, 1'b0, "pass_rhs"};
    vecs[8]  = '{4'b0011, 8'hCA, 8'h5C, 8'h35, 1'b0, 1'b0, 1'b0, "not_lhs"};
    vecs[9]  = '{4'b0101, 8'hCA, 8'h5C, 8'hA3, 1'b0, 1'b1, 1'b0, "not_rhs"};
    vecs[10] = '{4'b0000, 8'hCA, 8'h5C, 8'h00, 1'b1, 1'b0, 1'b0, "zero_fn"};
    vecs[11] = '{4'b1111, 8'hCA, 8'h5C, 8'hFF, 1'b0, 1'b1, 1'b0, "ones_fn"};
    vecs[12] = '{4'b0110, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, "xor_equal"};
    vecs[13] = '{4'b1110, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, "or_parity0"};
    vecs[14] = '{4'b1100, 8'h07, 8'h00, 8'h07, 1'b0, 1'b0, 1'b1, "lhs_parity1"};
    vecs[15] = '{4'b1000, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, "and_low"};

    b.in_valid     = 1'b0;
    b.LogicSelect  = '0;
    b.LHSIn        = '0;
    b.RHSIn        = '0;
    b.out_ready    = 1'b1;
    wb.in_valid    = 1'b0;
    wb.LogicSelect = '0;
    wb.LHSIn       = '0;
    wb.RHSIn       = '0;
    wb.out_ready   = 1'b1;

    // ---- reset state ----
    #12;
    check("reset out_valid", b.out_valid, 0);
    check("reset result", b.RHSOut, 0);
    check("reset zero", b.ZeroOut, 0);
    check("reset sign", b.SignOut, 0);
    check("reset in_ready", b.in_ready, 1);
`ifdef ALU_LOGIC_PARITY_EN
    check("reset parity", b.ParityOut, 0);
`endif
    #10 rst_n = 1'b1;
    to_drive();

    // ---- table of isolated operations ----
    for (int i = 0; i < 16; i++) begin
      run_single(vecs[i].sel, vecs[i].lhs, vecs[i].rhs, vecs[i].res,
                 vecs[i].z, vecs[i].s, vecs[i].p, vecs[i].name);
    end

    // ---- back-to-back issue, one result per cycle ----
    for (int c = 0; c < 6; c++) begin
      b.in_valid = (c < 4);
      if (c < 4) b.LogicSelect = bsel[c];
      b.LHSIn     = 8'hCA;
      b.RHSIn     = 8'h5C;
      b.out_ready = 1'b1;
      @(negedge clk);
      if (c < 2) begin
        check("b2b early_valid", b.out_valid, 0);
      end else begin
        check("b2b valid", b.out_valid, 1);
        check("b2b result", b.RHSOut, bexp[c-2]);
        check("b2b sign", b.SignOut, bsgn[c-2]);
        check("b2b zero", b.ZeroOut, 0);
      end
      to_drive();
    end
    b.in_valid = 1'b0;

    // ---- stall: 3 ops offered with out_ready low ----
    b.out_ready = 1'b0;
    idx         = 0;
    have_held   = 1'b0;
    held        = '0;
    for (int c = 0; c < 6; c++) begin
      b.in_valid = (idx < 3);
      if (idx < 3) b.LogicSelect = bsel[idx];
      @(negedge clk);
      if (c == 1) check("stall ready_second", b.in_ready, 1);
      if (c >= 2) check("stall ready_low", b.in_ready, 0);
      if (b.out_valid) begin
        if (!have_held) begin
          held      = b.RHSOut;
          have_held = 1'b1;
        end else begin
          check("stall result_hold", b.RHSOut, held);
        end
      end
      if (b.in_valid && b.in_ready) idx++;
      to_drive();
    end
    check("stall accepts", idx, 2);
    check("stall held_value", held, 8'h48);
    b.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      b.in_valid = (idx < 3);
      if (idx < 3) b.LogicSelect = bsel[idx];
      @(negedge clk);
      check("drain valid", b.out_valid, 1);
      check("drain result", b.RHSOut, bexp[c]);
      if (b.in_valid && b.in_ready) idx++;
      to_drive();
    end
    b.in_valid = 1'b0;
    @(negedge clk);
    check("drain empty", b.out_valid, 0);
    check("drain accepts", idx, 3);
    to_drive();

    // ---- flush with 2 ops in flight and a simultaneous offer ----
    b.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      b.in_valid    = 1'b1;
      b.LogicSelect = bsel[c];
      to_drive();
    end
    flush         = 1'b1;
    b.in_valid    = 1'b1;
    b.LogicSelect = 4'b0001;
    b.out_ready   = 1'b1;
    @(negedge clk);
    check("flush in_ready", b.in_ready, 1);
    check("flush pre_valid", b.out_valid, 1);
    to_drive();
    flush      = 1'b0;
    b.in_valid = 1'b0;
    seen       = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) check("flush valid_next", b.out_valid, 0);
      if (b.out_valid) seen = 1'b1;
      to_drive();
    end
    check("flush no_result", seen, 0);

    // ---- asynchronous reset mid-stream ----
    b.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      b.in_valid    = 1'b1;
      b.LogicSelect = bsel[1 - c];
      to_drive();
    end
    b.in_valid = 1'b0;
    @(negedge clk);
    check("areset pre_valid", b.out_valid, 1);
    check("areset pre_result", b.RHSOut, 8'hDE);
    #2 rst_n = 1'b0;
    #1;
    check("areset valid", b.out_valid, 0);
    check("areset result", b.RHSOut, 0);
    check("areset zero", b.ZeroOut, 0);
    check("areset sign", b.SignOut, 0);
    check("areset in_ready", b.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    to_drive();
    run_single(4'b1000, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, "after_reset");

    // ---- 16-bit instance, zero flag also on all-ones ----
    run_wide(4'b0110, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b1, "wide_xor");
    run_wide(4'b1111, 16'h1234, 16'h5678, 16'hFFFF, 1'b1, 1'b1, 1'b0, "wide_ones");
    run_wide(4'b0000, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, "wide_zero");
    run_wide(4'b1001, 16'h1234, 16'h1234, 16'hFFFF, 1'b1, 1'b1, 1'b0, "wide_xnor");

    // ---- randomized traffic against the scoreboard ----
    pv   = 1'b0;
    pr   = 1'b0;
    pf   = 1'b0;
    pres = '0;
    for (int c = 0; c < 3000; c++) begin
      flush         = ($urandom_range(0, 39) == 0);
      b.in_valid    = ($urandom_range(0, 3) != 0);
      b.LogicSelect = 4'($urandom);
      b.LHSIn       = 8'($urandom);
      b.RHSIn       = 8'($urandom);
      b.out_ready   = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      check("rnd in_ready", b.in_ready, !(q.size() == 2 && !b.out_ready));
      if (pf) check("rnd flush_clears", b.out_valid, 0);
      if (pv && !pr && !pf) begin
        check("rnd stall_valid", b.out_valid, 1);
        check("rnd stall_data", b.RHSOut, pres);
      end
      if (b.out_valid && b.out_ready) begin
        if (q.size() == 0) begin
          check("rnd unexpected_result", b.out_valid, 0);
        end else begin
          e = q.pop_front();
          check("rnd result", b.RHSOut, e);
          check("rnd zero", b.ZeroOut, (e == 8'h00));
          check("rnd sign", b.SignOut, e[7]);
`ifdef ALU_LOGIC_PARITY_EN
          check("rnd parity", b.ParityOut, ^e);
`endif
        end
      end
      if (flush) q.delete();
      else if (b.in_valid && b.in_ready)
        q.push_back(ref_fn(b.LogicSelect, b.LHSIn, b.RHSIn));
      pv   = b.out_valid;
      pr   = b.out_ready;
      pf   = flush;
      pres = b.RHSOut;
      to_drive();
    end
    flush       = 1'b0;
    b.in_valid  = 1'b0;
    b.out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (b.out_valid) begin
        e = q.pop_front();
        check("rnd drain_result", b.RHSOut, e);
      end
      to_drive();
    end
    check("rnd drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_logic_pipe.md
Name: alu_logic_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit ALU logic unit.
- Computes any of the 16 two-input bitwise boolean functions of LHS and RHS, selected by a 4-bit truth-table code.
- Two register stages with valid/ready handshakes on both sides; also produces zero and sign flags.
- Sits between operand fetch and the ALU result mux; can stall without losing data.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- FLAG_ZERO_ALL_ONES, 0, when 1, ZeroOut also asserts for an all-ones result (compare-equal-after-XNOR use).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; drops all in-flight operations.
- in_valid  input  1  operands and select are valid.
- in_ready  output  1  stage 1 can accept this cycle.
- LogicSelect  input  4  truth-table function code.
- LHSIn  input  WIDTH  left operand.
- RHSIn  input  WIDTH  right operand.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- RHSOut  output  WIDTH  result.
- ZeroOut  output  1  result flag, see Behaviour.
- SignOut  output  1  result MSB.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, RHSOut=0, ZeroOut=0, SignOut=0, parity=0. Datapath registers are also cleared.
- Function: RHSOut[i] = LogicSelect[{LHSIn[i],RHSIn[i]}], where index 0 is LHS=0,RHS=0 and index 3 is LHS=1,RHS=1. Codes: 0000 zero, 1000 AND, 1110 OR, 0110 XOR, 1001 XNOR, 0111 NAND, 0001 NOR, 1100 pass LHS, 1010 pass RHS, 0011 NOT LHS, 0101 NOT RHS, 1111 all ones.
- Stage 1: on accept (in_valid && in_ready), registers LHSIn, RHSIn and LogicSelect, and sets s1_valid=1.
- Stage 2: when s1_valid && (!out_valid || out_ready), computes the function from the stage-1 registers and registers RHSOut, ZeroOut (result==0, OR result==all-ones when FLAG_ZERO_ALL_ONES=1), SignOut=result[WIDTH-1], and out_valid=1.
- Otherwise: out_valid clears when out_valid && out_ready and no new result is loaded.
- in_ready = !s1_valid || !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Latency: 2 cycles from accept edge to out_valid with no stall. Throughput: 1 op/cycle while out_ready=1.
- Back-pressure: while out_ready=0 and both stages are full, in_ready=0 and all registers hold. There is no loss and no duplication.
- Simultaneous out_ready and new stage-2 load: the old result is consumed and the new one loaded in the same edge; out_valid stays 1.
- Output stability: while out_valid=1 and out_ready=0, RHSOut and the flags must not change.
- flush: at the next edge, s1_valid=0 and out_valid=0; data registers may hold stale values. flush wins over a simultaneous accept (that input is dropped). in_ready is unaffected by flush.
- Reset mid-operation: all in-flight ops are lost; the first accept after rst_n rises behaves as from idle.
- Order: strictly in order; at most 2 ops in flight.

Optional Feature:
- Macro: ALU_LOGIC_PARITY_EN.
- Defined: adds output ParityOut (1 bit) = XOR-reduce of the registered result, loaded in stage 2 alongside the other flags, reset 0, held under stall, and cleared with out_valid on flush.
- Undefined: no ParityOut port and no parity logic; all other behaviour is identical.

Test Plan (WIDTH=8 unless stated):
- Functions: LHS=0xCA, RHS=0x5C, out_ready=1, issue AND, OR, XOR, NOT LHS back to back. Expect 0x48, 0xDE, 0x96, 0x35 on consecutive cycles, first one 2 cycles after the first accept; flags Z=0 and S=0,1,1,0.
- Zero/sign: XOR with LHS=RHS=0xA5 gives 0x00, Z=1, S=0. Code 1111 gives 0xFF, Z=0 (Z=1 with FLAG_ZERO_ALL_ONES=1), S=1.
- Stall: 3 ops issued with out_ready=0. Expect in_ready to drop after 2 accepts; the third is held by the source; RHSOut stays constant. Then raise out_ready for 3 cycles: all 3 results come out in order with no gaps.
- Flush: with 2 ops in flight, pulse flush together with in_valid=1. Next cycle out_valid=0 and s1 empty; no result for the dropped op ever appears.
- Async reset: assert rst_n low mid-stream between clock edges. Outputs go to 0 immediately; after release, op AND 0xFF,0x0F yields 0x0F after 2 cycles.
- Parity (ALU_LOGIC_PARITY_EN defined): OR of 0x01 and 0x02 gives 0x03 with ParityOut=0; pass LHS of 0x07 gives ParityOut=1. With WIDTH=16, XOR of 0xFFFF and 0x0001 gives 0xFFFE, S=1, parity=1.
